// File: rtl/reg_rename_file_if.sv
// Decoder/ROB-facing bundle of the rename register file: rename, commit, flush and source reads.
// "master" is the decoder/ROB side, "slave" is the register file.
interface reg_rename_file_if #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
);
    logic                      dec_rename_valid;
    logic [REG_NUM_WIDTH-1:0]  dec_rename_rd;
    logic [ROB_SIZE_WIDTH-1:0] dec_rename_tag;
    logic [REG_NUM_WIDTH-1:0]  dec_rs1;
    logic [REG_NUM_WIDTH-1:0]  dec_rs2;
    logic                      rob_commit_valid;
    logic [REG_NUM_WIDTH-1:0]  rob_commit_rd;
    logic [31:0]               rob_commit_value;
    logic [ROB_SIZE_WIDTH:0]   rob_commit_dep;
    logic                      flush_in;
    logic [31:0]               rs1_value;
    logic [ROB_SIZE_WIDTH:0]   rs1_dep;
    logic [31:0]               rs2_value;
    logic [ROB_SIZE_WIDTH:0]   rs2_dep;
    logic [5:0]                pending_count;

    modport master (
        output dec_rename_valid, dec_rename_rd, dec_rename_tag, dec_rs1, dec_rs2,
        output rob_commit_valid, rob_commit_rd, rob_commit_value, rob_commit_dep, flush_in,
        input  rs1_value, rs1_dep, rs2_value, rs2_dep, pending_count
    );

    modport slave (
        input  dec_rename_valid, dec_rename_rd, dec_rename_tag, dec_rs1, dec_rs2,
        input  rob_commit_valid, rob_commit_rd, rob_commit_value, rob_commit_dep, flush_in,
        output rs1_value, rs1_dep, rs2_value, rs2_dep, pending_count
    );
endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags; commit/rename visible next cycle,
// matching commits bypassed to reads in the same cycle. rdy_in low freezes all state.
module reg_rename_file #(
    parameter int REG_NUM_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    reg_rename_file_if.slave  bus
);
    localparam int NREG  = 1 << REG_NUM_WIDTH;
    localparam int TAG_W = ROB_SIZE_WIDTH + 1;
    localparam logic [TAG_W-1:0] NO_DEP = '1;

    logic [31:0]      r_value [NREG];
    logic [TAG_W-1:0] r_tag   [NREG];
    logic [5:0]       r_pending;

    logic [TAG_W-1:0] w_tag_nxt [NREG];
    logic [5:0]       w_count;
    logic             w_commit_wr;
    logic             w_rs1_byp;
    logic             w_rs2_byp;

    assign w_commit_wr = bus.rob_commit_valid && (bus.rob_commit_rd != '0);

    // Rename is applied after the commit clear so a same-cycle rename owns the register.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < NREG; i++) begin
            w_tag_nxt[i] = r_tag[i];
            if (i == 0 || bus.flush_in) begin
                w_tag_nxt[i] = NO_DEP;
            end else begin
                if (bus.rob_commit_valid && bus.rob_commit_rd == REG_NUM_WIDTH'(i)
                    && r_tag[i] == bus.rob_commit_dep)
                    w_tag_nxt[i] = NO_DEP;
                if (bus.dec_rename_valid && bus.dec_rename_rd == REG_NUM_WIDTH'(i))
                    w_tag_nxt[i] = {1'b0, bus.dec_rename_tag};
            end
            w_count = w_count + {5'd0, ~w_tag_nxt[i][TAG_W-1]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= NO_DEP;
            end
            r_pending <= '0;
        end else if (rdy_in) begin
            if (w_commit_wr)
                r_value[bus.rob_commit_rd] <= bus.rob_commit_value;
            for (int i = 0; i < NREG; i++)
                r_tag[i] <= w_tag_nxt[i];
            r_pending <= w_count;
        end
    end

    assign w_rs1_byp = w_commit_wr && (bus.rob_commit_rd == bus.dec_rs1)
                       && (bus.rob_commit_dep == r_tag[bus.dec_rs1]);
    assign w_rs2_byp = w_commit_wr && (bus.rob_commit_rd == bus.dec_rs2)
                       && (bus.rob_commit_dep == r_tag[bus.dec_rs2]);

    assign bus.rs1_value = (bus.dec_rs1 == '0) ? 32'd0 :
                           w_rs1_byp ? bus.rob_commit_value : r_value[bus.dec_rs1];
    assign bus.rs1_dep   = (bus.dec_rs1 == '0 || w_rs1_byp) ? NO_DEP : r_tag[bus.dec_rs1];
    assign bus.rs2_value = (bus.dec_rs2 == '0) ? 32'd0 :
                           w_rs2_byp ? bus.rob_commit_value : r_value[bus.dec_rs2];
    assign bus.rs2_dep   = (bus.dec_rs2 == '0 || w_rs2_byp) ? NO_DEP : r_tag[bus.dec_rs2];

    assign bus.pending_count = r_pending;
endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed scenarios then randomized traffic
// against an array-based model of values and pending producers.
module tb_reg_rename_file;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    reg_rename_file_if #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) bus ();

    reg_rename_file #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: value per register and producer id per register (-1 = no pending producer).
    int unsigned m_val [32];
    int          m_tag [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] enc(input int t);
        return (t < 0) ? 6'h3F : 6'(t);
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 1; i < 32; i++) if (m_tag[i] >= 0) c++;
        return c;
    endfunction

    function automatic logic byp(input int rs);
        return bus.rob_commit_valid && rs != 0 && int'(bus.rob_commit_rd) == rs
               && bus.rob_commit_dep == enc(m_tag[rs]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = 0;
            m_tag[i] = -1;
        end
    endtask

    task automatic model_clock();
        int crd = int'(bus.rob_commit_rd);
        int rrd = int'(bus.dec_rename_rd);
        if (bus.rob_commit_valid && crd != 0) begin
            m_val[crd] = bus.rob_commit_value;
            if (enc(m_tag[crd]) == bus.rob_commit_dep) m_tag[crd] = -1;
        end
        if (bus.flush_in) begin
            for (int i = 0; i < 32; i++) m_tag[i] = -1;
        end else if (bus.dec_rename_valid && rrd != 0) begin
            m_tag[rrd] = int'(bus.dec_rename_tag);
        end
    endtask

    // Check both read ports against the model, clock once, then check pending_count.
    task automatic step();
        int r1, r2;
        #1;
        r1 = int'(bus.dec_rs1);
        r2 = int'(bus.dec_rs2);
        chk("rs1_value", bus.rs1_value, byp(r1) ? bus.rob_commit_value : m_val[r1]);
        chk("rs1_dep",   bus.rs1_dep,   byp(r1) ? 6'h3F : enc(m_tag[r1]));
        chk("rs2_value", bus.rs2_value, byp(r2) ? bus.rob_commit_value : m_val[r2]);
        chk("rs2_dep",   bus.rs2_dep,   byp(r2) ? 6'h3F : enc(m_tag[r2]));
        @(posedge clk_in);
        if (rdy_in) model_clock();
        #1;
        chk("pending_count", bus.pending_count, m_count());
    endtask

    task automatic idle(input int rs1, input int rs2);
        rdy_in = 1'b1;
        bus.dec_rename_valid = 1'b0; bus.dec_rename_rd = '0; bus.dec_rename_tag = '0;
        bus.rob_commit_valid = 1'b0; bus.rob_commit_rd = '0;
        bus.rob_commit_value = '0;   bus.rob_commit_dep = 6'h3F;
        bus.flush_in = 1'b0;
        bus.dec_rs1 = 5'(rs1);
        bus.dec_rs2 = 5'(rs2);
    endtask

    task automatic rename(input int rd, input int tag);
        bus.dec_rename_valid = 1'b1;
        bus.dec_rename_rd    = 5'(rd);
        bus.dec_rename_tag   = 5'(tag);
    endtask

    task automatic commit(input int rd, input int dep, input logic [31:0] val);
        bus.rob_commit_valid = 1'b1;
        bus.rob_commit_rd    = 5'(rd);
        bus.rob_commit_dep   = 6'(dep);
        bus.rob_commit_value = val;
    endtask

    initial begin
        model_reset();
        idle(5, 0);
        rst_in = 1'b0;
        #12;
        chk("rst_rs1_value", bus.rs1_value, 32'd0);
        chk("rst_rs1_dep",   bus.rs1_dep,   6'h3F);
        chk("rst_rs2_value", bus.rs2_value, 32'd0);
        chk("rst_rs2_dep",   bus.rs2_dep,   6'h3F);
        chk("rst_pending",   bus.pending_count, 6'd0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Rename then matching commit with bypass.
        idle(5, 0); rename(5, 3); step();
        idle(5, 0); commit(5, 3, 32'hDEADBEEF);
        #1;
        chk("byp_value", bus.rs1_value, 32'hDEADBEEF);
        chk("byp_dep",   bus.rs1_dep,   6'h3F);
        step();
        idle(5, 0); #1;
        chk("post_commit_dep", bus.rs1_dep, 6'h3F);
        chk("post_commit_pending", bus.pending_count, 6'd0);
        step();

        // Stale commit against a younger producer.
        idle(7, 0); rename(7, 2); step();
        idle(7, 0); rename(7, 9); step();
        idle(7, 0); commit(7, 2, 32'h11); #1;
        chk("stale_nobyp_dep",   bus.rs1_dep,   6'd9);
        chk("stale_nobyp_value", bus.rs1_value, 32'd0);
        step();
        idle(7, 0); #1;
        chk("stale_value",   bus.rs1_value, 32'h11);
        chk("stale_dep",     bus.rs1_dep,   6'd9);
        chk("stale_pending", bus.pending_count, 6'd1);
        step();

        // Same-cycle commit and rename: rename wins.
        idle(4, 0); rename(4, 1); step();
        idle(4, 0); commit(4, 1, 32'h40); rename(4, 6); step();
        idle(4, 0); #1;
        chk("cr_value", bus.rs1_value, 32'h40);
        chk("cr_dep",   bus.rs1_dep,   6'd6);
        step();

        // Flush with concurrent commit and discarded rename.
        for (int r = 1; r <= 3; r++) begin
            idle(r, 0); rename(r, r + 3); step();
        end
        idle(1, 9); flush_set(); commit(1, 6'h3F, 32'h80000004); rename(9, 7); step();
        idle(1, 9); #1;
        chk("flush_pending", bus.pending_count, 6'd0);
        chk("flush_value1",  bus.rs1_value, 32'h80000004);
        chk("flush_dep1",    bus.rs1_dep,   6'h3F);
        chk("flush_dep9",    bus.rs2_dep,   6'h3F);
        step();

        // rdy_in low holds state.
        idle(8, 0); rdy_in = 1'b0; rename(8, 10); step(); step();
        idle(8, 0); #1;
        chk("hold_dep8", bus.rs1_dep, 6'h3F);
        step();

        // x0 is immutable.
        idle(0, 0); rename(0, 1); commit(0, 6'h3F, 32'd5); #1;
        chk("x0_byp_value", bus.rs1_value, 32'd0);
        step();
        idle(0, 0); #1;
        chk("x0_value", bus.rs1_value, 32'd0);
        chk("x0_dep",   bus.rs1_dep,   6'h3F);
        step();

        // Asynchronous reset mid-cycle.
        idle(4, 7); rename(12, 3); step();
        idle(4, 7); #2;
        rst_in = 1'b0; #1;
        chk("arst_pending", bus.pending_count, 6'd0);
        chk("arst_value4",  bus.rs1_value, 32'd0);
        chk("arst_dep7",    bus.rs2_dep,   6'h3F);
        model_reset();
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int crd, rs1, rs2, dsel;
            idle(0, 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1) rename($urandom_range(0, 31), $urandom_range(0, 31));
            crd = $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) begin
                dsel = $urandom_range(0, 9);
                commit(crd, (dsel < 6) ? int'(enc(m_tag[crd])) :
                            (dsel < 9) ? int'($urandom_range(0, 31)) : 63, $urandom());
            end
            bus.flush_in = ($urandom_range(0, 31) == 0);
            rs1 = ($urandom_range(0, 2) == 0) ? crd : int'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 2) == 0) ? crd : int'($urandom_range(0, 31));
            bus.dec_rs1 = 5'(rs1);
            bus.dec_rs2 = 5'(rs2);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic flush_set();
        bus.flush_in = 1'b1;
    endtask
endmodule
